ysyx_22041412_mem_rsp: RTL and testbench

Memory-side responder for the fetch/load read handshake (valid_o/ready_i/r_size/r_addr/r_data) used by the core's instruction fetch unit. Accepts one read request at a time and looks it up in an internal word array. After a configurable latency it returns read data with a one-cycle ready pulse. It serves as the simulation memory model for NPC and includes a preload port for the bench or loader.

---
 rtl/ysyx_22041412_mem_pkg.sv | 47 ++++
 rtl/ysyx_22041412_mem_array.sv | 31 +++
 rtl/ysyx_22041412_mem_rsp.sv | 132 +++++++++++++
 tb/tb_ysyx_22041412_mem_rsp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041412_mem_pkg.sv
// Shared definitions for the memory responder.
// Holds the size codes, the FSM state type, the default base address and
// the helpers that check alignment and pick byte/half lanes.
package ysyx_22041412_mem_pkg;

  localparam logic [7:0]  SZ_B       = 8'h00;
  localparam logic [7:0]  SZ_H       = 8'h01;
  localparam logic [7:0]  SZ_W       = 8'h02;
  localparam logic [7:0]  SZ_W_FETCH = 8'h03;

  localparam logic [63:0] DEFAULT_BASE = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Legal size code and natural alignment for the low address bits
  function automatic logic size_ok(input logic [7:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_B:             return 1'b1;
      SZ_H:             return ~lo[0];
      SZ_W, SZ_W_FETCH: return (lo == 2'b00);
      default:          return 1'b0;
    endcase
  endfunction

  // Right-align and zero-extend the addressed lane of a word
  function automatic logic [31:0] lane_select(input logic [31:0] w,
                                              input logic [7:0]  sz,
                                              input logic [1:0]  lo);
    logic [31:0] t;
    case (sz)
      SZ_B: begin
        t = w >> {lo, 3'b000};
        return {24'h0, t[7:0]};
      end
      SZ_H: begin
        t = w >> {lo[1], 4'b0000};
        return {16'h0, t[15:0]};
      end
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041412_mem_array.sv
// DEPTH x 32 word storage.
// Ports: clk, rst (async, clears only the read register), we/waddr/wdata
// synchronous write, re/raddr synchronous read into rdata.
// A write and a read of the same word at one edge return the old word.
module ysyx_22041412_mem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Contents are never reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ysyx_22041412_mem_rsp.sv
// Memory-side responder for the fetch/load read handshake.
// Ports: clk, rst (async, active-high); valid_i/r_size_i/r_addr_i request;
// ready_o one-cycle response pulse with r_data_o and err_o;
// load_en_i/load_addr_i/load_data_i preload write port.
// Response arrives LATENCY cycles after the accepting edge.
module ysyx_22041412_mem_rsp
  import ysyx_22041412_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 64,
  parameter int unsigned       DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE    = ADDR_W'(DEFAULT_BASE),
  parameter int unsigned       LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [7:0]        r_size_i,
  input  logic [ADDR_W-1:0] r_addr_i,
  output logic              ready_o,
  output logic [31:0]       r_data_o,
  output logic              err_o,
  input  logic              load_en_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [31:0]       load_data_i
);

  localparam int unsigned       IDX_W = $clog2(DEPTH);
  localparam int unsigned       CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 4);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        size_q;

  // Held response shaping; r_data_o keeps its value after ready_o drops
  logic              bad_q;
  logic [7:0]        sz_q;
  logic [1:0]        lo_q;

  logic [31:0]       rdata;

  // Request decode: in IDLE the live request is decoded so LATENCY=1 works
  logic [ADDR_W-1:0] dec_addr;
  logic [7:0]        dec_size;
  logic [ADDR_W:0]   dec_diff;
  logic              dec_bad;
  logic [IDX_W-1:0]  dec_idx;
  logic              fire;

  always_comb begin
    dec_addr = (state == IDLE) ? r_addr_i : addr_q;
    dec_size = (state == IDLE) ? r_size_i : size_q;
    dec_diff = {1'b0, dec_addr} - {1'b0, BASE};
    dec_bad  = dec_diff[ADDR_W] || (dec_diff[ADDR_W-1:0] >= SPAN) ||
               !size_ok(dec_size, dec_addr[1:0]);
    dec_idx  = dec_diff[IDX_W+1:2];
    fire     = ((state == IDLE) && valid_i && (LATENCY == 1)) ||
               ((state == WAIT) && (cnt == CNT_W'(1)));
  end

  // Preload decode; out-of-range writes are dropped
  logic [ADDR_W:0]   ld_diff;
  logic              ld_we;
  logic [IDX_W-1:0]  ld_idx;

  always_comb begin
    ld_diff = {1'b0, load_addr_i} - {1'b0, BASE};
    ld_we   = load_en_i && !ld_diff[ADDR_W] && (ld_diff[ADDR_W-1:0] < SPAN);
    ld_idx  = ld_diff[IDX_W+1:2];
  end

  ysyx_22041412_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (ld_we),
    .waddr (ld_idx),
    .wdata (load_data_i),
    .re    (fire),
    .raddr (dec_idx),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      bad_q   <= 1'b0;
      sz_q    <= '0;
      lo_q    <= '0;
    end else begin
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            addr_q <= r_addr_i;
            size_q <= r_size_i;
            cnt    <= CNT_W'(LATENCY - 1);
            state  <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (fire) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // The array read lands at this same edge; shaping info is captured alongside
      if (fire) begin
        ready_o <= 1'b1;
        err_o   <= dec_bad;
        bad_q   <= dec_bad;
        sz_q    <= dec_size;
        lo_q    <= dec_addr[1:0];
      end
    end
  end

  always_comb begin
    r_data_o = bad_q ? '0 : lane_select(rdata, sz_q, lo_q);
  end

endmodule

// File: tb/tb_ysyx_22041412_mem_rsp.sv
// Directed self-checking bench for ysyx_22041412_mem_rsp (LATENCY=2).
module tb_ysyx_22041412_mem_rsp;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [7:0]  r_size_i;
  logic [63:0] r_addr_i;
  logic        ready_o;
  logic [31:0] r_data_o;
  logic        err_o;
  logic        load_en_i;
  logic [63:0] load_addr_i;
  logic [31:0] load_data_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_22041412_mem_rsp #(
    .ADDR_W  (64),
    .DEPTH   (1024),
    .BASE    (64'h8000_0000),
    .LATENCY (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .r_size_i    (r_size_i),
    .r_addr_i    (r_addr_i),
    .ready_o     (ready_o),
    .r_data_o    (r_data_o),
    .err_o       (err_o),
    .load_en_i   (load_en_i),
    .load_addr_i (load_addr_i),
    .load_data_i (load_data_i)
  );

  typedef struct {
    logic [7:0]  sz;
    logic [63:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [63:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en_i = 1'b1; load_addr_i = a; load_data_i = d;
    @(posedge clk);
    #1 load_en_i = 1'b0;
  endtask

  // Drives a request (and optionally a load) so both are sampled at the accepting edge
  task automatic issue(input logic [7:0] sz, input logic [63:0] a,
                       input bit do_ld, input logic [63:0] la, input logic [31:0] ld);
    @(negedge clk);
    valid_i = 1'b1; r_size_i = sz; r_addr_i = a;
    if (do_ld) begin
      load_en_i = 1'b1; load_addr_i = la; load_data_i = ld;
    end
    @(posedge clk);
    #1;
    valid_i   = 1'b0;
    load_en_i = 1'b0;
  endtask

  // Counts negedges until ready_o; lat stays 0 on timeout
  task automatic wait_rsp(output logic [31:0] d, output logic e, output int lat);
    d = '0; e = 1'b0; lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ready_o) begin
        d = r_data_o; e = err_o; lat = i;
        break;
      end
    end
  endtask

  logic [31:0] d;
  logic        e;
  int          lat;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pcw [4];
    int          k, last, consec, rdy_cnt;
    bit          prev_rdy;

    vecs[0]  = '{8'h03, 64'h8000_0000, 32'h0000_0413, 1'b0};
    vecs[1]  = '{8'h00, 64'h8000_0012, 32'h0000_00B2, 1'b0};
    vecs[2]  = '{8'h01, 64'h8000_0012, 32'h0000_A1B2, 1'b0};
    vecs[3]  = '{8'h01, 64'h8000_0011, 32'h0000_0000, 1'b1};
    vecs[4]  = '{8'h00, 64'h8000_0011, 32'h0000_00C3, 1'b0};
    vecs[5]  = '{8'h00, 64'h8000_0010, 32'h0000_00D4, 1'b0};
    vecs[6]  = '{8'h01, 64'h8000_0010, 32'h0000_C3D4, 1'b0};
    vecs[7]  = '{8'h02, 64'h8000_0010, 32'hA1B2_C3D4, 1'b0};
    vecs[8]  = '{8'h02, 64'h8000_0012, 32'h0000_0000, 1'b1};
    vecs[9]  = '{8'h04, 64'h8000_0010, 32'h0000_0000, 1'b1};
    vecs[10] = '{8'h03, 64'h7FFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[11] = '{8'h03, 64'h8000_1000, 32'h0000_0000, 1'b1};
    vecs[12] = '{8'h03, 64'h8000_0FFC, 32'hDEAD_BEEF, 1'b0};
    vecs[13] = '{8'h00, 64'h8000_0FFF, 32'h0000_00DE, 1'b0};
    vecs[14] = '{8'h03, 64'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[15] = '{8'h03, 64'hFFFF_FFFF_8000_0000, 32'h0000_0000, 1'b1};
    pcw[0] = 32'h0000_0413; pcw[1] = 32'h0010_0093;
    pcw[2] = 32'h0020_0113; pcw[3] = 32'h0030_0193;

    rst = 1'b1; valid_i = 1'b0; r_size_i = '0; r_addr_i = '0;
    load_en_i = 1'b0; load_addr_i = '0; load_data_i = '0;
    #22;
    chk("reset_ready", 64'(ready_o), 64'h0);
    chk("reset_data",  64'(r_data_o), 64'h0);
    chk("reset_err",   64'(err_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) preload(64'h8000_0000 + 64'(4 * i), pcw[i]);
    preload(64'h8000_0010, 32'hA1B2_C3D4);
    preload(64'h8000_0FFC, 32'hDEAD_BEEF);
    preload(64'h8000_0020, 32'h1111_1111);
    // Out-of-range loads must not alias onto words 0 or 1023
    preload(64'h8000_1000, 32'h5555_5555);
    preload(64'h7FFF_FFFC, 32'h6666_6666);

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].sz, vecs[i].addr, 1'b0, '0, '0);
      wait_rsp(d, e, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_data", i), 64'(d), 64'(vecs[i].data));
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].err));
      @(negedge clk);
      chk($sformatf("vec%0d_ready_drop", i), 64'(ready_o), 64'h0);
      chk($sformatf("vec%0d_err_drop", i), 64'(err_o), 64'h0);
      chk($sformatf("vec%0d_data_hold", i), 64'(r_data_o), 64'(vecs[i].data));
    end

    // Back-to-back fetch: valid re-raised as soon as each response is seen
    k = 0; last = 0; consec = 0; prev_rdy = 1'b0;
    @(negedge clk);
    valid_i = 1'b1; r_size_i = 8'h03; r_addr_i = 64'h8000_0000;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (ready_o && prev_rdy) consec++;
      prev_rdy = ready_o;
      if (ready_o) begin
        chk($sformatf("b2b_data%0d", k), 64'(r_data_o), 64'(pcw[k]));
        if (k > 0) chk($sformatf("b2b_spacing%0d", k), 64'(cyc - last), 64'd3);
        last = cyc;
        k++;
        if (k == 4) begin
          valid_i = 1'b0;
          break;
        end
        r_addr_i = 64'h8000_0000 + 64'(4 * k);
      end
    end
    valid_i = 1'b0;
    chk("b2b_count", 64'(k), 64'd4);
    @(negedge clk);
    chk("b2b_no_consecutive_ready", 64'(consec), 64'd0);

    // Load at the accepting edge lands before the read edge
    issue(8'h03, 64'h8000_0020, 1'b1, 64'h8000_0020, 32'h2222_2222);
    wait_rsp(d, e, lat);
    chk("collide_early_data", 64'(d), 64'h2222_2222);
    preload(64'h8000_0020, 32'h1111_1111);

    // Load at the same edge that raises ready_o returns the old word
    issue(8'h03, 64'h8000_0020, 1'b0, '0, '0);
    load_en_i = 1'b1; load_addr_i = 64'h8000_0020; load_data_i = 32'h2222_2222;
    @(posedge clk);
    #1 load_en_i = 1'b0;
    wait_rsp(d, e, lat);
    chk("collide_same_latency", 64'(lat), 64'd1);
    chk("collide_same_data", 64'(d), 64'h1111_1111);
    issue(8'h03, 64'h8000_0020, 1'b0, '0, '0);
    wait_rsp(d, e, lat);
    chk("collide_after_data", 64'(d), 64'h2222_2222);

    // Async reset during WAIT abandons the request
    issue(8'h03, 64'h8000_0010, 1'b0, '0, '0);
    #2;
    chk("rst_mid_hold_data", 64'(r_data_o), 64'h2222_2222);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", 64'(ready_o), 64'h0);
    chk("rst_mid_data", 64'(r_data_o), 64'h0);
    chk("rst_mid_err", 64'(err_o), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rdy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ready_o) rdy_cnt++;
    end
    chk("rst_mid_no_pulse", 64'(rdy_cnt), 64'd0);
    issue(8'h02, 64'h8000_0010, 1'b0, '0, '0);
    wait_rsp(d, e, lat);
    chk("rst_after_latency", 64'(lat), 64'd2);
    chk("rst_after_data", 64'(d), 64'hA1B2_C3D4);
    chk("rst_after_err", 64'(e), 64'h0);
    issue(8'h03, 64'h8000_000C, 1'b0, '0, '0);
    wait_rsp(d, e, lat);
    chk("rst_after_data2", 64'(d), 64'h0030_0193);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
